audio_tone_gen: RTL
===================

# audio_tone_gen

Parametrised multi-waveform tone source for the audio peripheral. It generates a square, sawtooth or triangle sample stream with a runtime-programmable period, duty, amplitude and slope. The phase advances only on a sample-rate strobe, so the sample rate is set outside the block. New settings are double-buffered and applied glitch-free at a period boundary. The output feeds the audio mixer/DAC path as unsigned 16-bit-class samples.

## Interface
- DATA_W, 16, sample width
- CNT_W, 18, phase counter / period / duty width
- DEFAULT_PERIOD, 128, period after reset (in samples)
- CLK  in  1  clock
- RST_N  in  1  reset; synchronous, active-low
- enable  in  1  generator run; low = idle, output 0
- sample_en  in  1  one-cycle strobe; advance one sample when enable=1
- load  in  1  one-cycle strobe; capture cfg inputs into pending buffer
- cfg_period  in  CNT_W  samples per period
- cfg_duty  in  CNT_W  square high length in samples
- cfg_amp  in  DATA_W  peak level
- cfg_step  in  DATA_W  saw/triangle slope per sample
- cfg_mode  in  2  0 square, 1 saw, 2 triangle, 3 silence
- data  out  DATA_W  current sample, registered
- valid  out  1  one-cycle pulse: new sample on data
- wrap  out  1  one-cycle pulse: sample just produced was the last of a period

## Operation
- Active registers: period_r, duty_r, amp_r, step_r, mode_r. Pending copies exist for each, plus a pend flag.
- On load, cfg_* is copied to pending and pend is set to 1. A second load before the values are applied overwrites the pending copy.
- cfg_period < 2 is clamped to 2 on capture. duty >= period gives a square wave that is high for the whole period.
- A sample is accepted in a cycle where enable=1 and sample_en=1. Let c be the phase count before the update and L the previous output level. The new sample f(c) is:
  - square: amp_r if c < duty_r, else 0.
  - saw: 0 if c==0; else min(L+step_r, amp_r). The sum is computed at DATA_W+1 bits, so there is no wrap-around.
  - triangle: let half = period_r>>1. Output 0 if c==0; min(L+step_r, amp_r) if c < half; otherwise max(L-step_r, 0) with saturation.
  - silence: 0.
- On each accepted sample: data<=f(c), valid<=1, and the count becomes c+1.
  - If c==period_r-1, the count becomes 0 and wrap<=1.
  - Also at c==period_r-1, if pend=1 the pending values are copied to the active registers and pend is cleared.
  - If load coincides with the boundary sample, the cfg_* values on that cycle become active directly and pend ends at 0.
- enable=0, checked each cycle:
  - count<=0, L<=0, data<=0; valid and wrap stay 0.
  - If pend=1, pending values are applied immediately.
  - Any load in that cycle is applied at the next cycle.
- enable=1 without sample_en: all state holds and valid=0.
- Reset (RST_N=0 at a CLK edge) has priority over everything and may be applied mid-period. It sets:
  - count=0, L=0, data=0, valid=0, wrap=0, pend=0.
  - period_r=DEFAULT_PERIOD, duty_r=DEFAULT_PERIOD/2, amp_r={2'b00,{DATA_W-2{1'b1}}} (0x3FFF at 16 bits), step_r=1, mode_r=0.
  - Pending registers are set to the same values as the active ones.

## Timing
- Latency is 1 cycle: an accepted strobe at edge t gives data, valid and wrap valid after edge t+1.
- valid and wrap are single-cycle pulses. They never assert without an accepted strobe on the previous cycle.
- Back-to-back strobes (sample_en held high) produce one sample per cycle.
- Settings never change mid-period while enable=1. The first sample after an applied change has c=0 under the new settings.
- Max throughput is one sample per CLK. There is no backpressure; the consumer must take data on valid.

## Test plan
- Reset, then enable=1 and sample_en held high → data=0x3FFF for 64 valids, then 0 for 64, with wrap on the 128th valid. The pattern repeats.
- Saw: load period=8, amp=100, step=30 with enable=0, then run → samples 0,30,60,90,100,100,100,100, with wrap on the 8th. The next period restarts at 0.
- Triangle: period=8, amp=100, step=40 → samples 0,40,80,100,60,20,0,0 (saturation on both ends).
- Mid-period load: while in square mode at c=10 of period 128, load period=4, duty=2 → the current period completes all 128 samples unchanged. Then the output is 0x3FFF,0x3FFF,0,0 repeating. Test the load-on-boundary cycle as a separate case.
- Clamping and gaps: load period=1, duty=5 → the effective period is 2 and data stays 0x3FFF every sample. Strobe every 3rd cycle → valid arrives exactly one cycle after each strobe, and there is no output change between strobes.
- Reset mid-run: assert RST_N=0 for 1 cycle at c=50 of a saw with a pending load → all outputs are 0, pend is cleared, the defaults are restored, and the next sample is 0x3FFF at c=0.

Source files
------------

// File: rtl/audio_tone_gen.sv
// Square / sawtooth / triangle tone source, advanced by an external sample strobe.
// Settings are double-buffered and take effect at a period boundary or while idle.
module audio_tone_gen #(
    parameter int DATA_W         = 16,
    parameter int CNT_W          = 18,
    parameter int DEFAULT_PERIOD = 128
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              enable,
    input  logic              sample_en,
    input  logic              load,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [DATA_W-1:0] cfg_amp,
    input  logic [DATA_W-1:0] cfg_step,
    input  logic [1:0]        cfg_mode,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              wrap
);

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SILENT = 2'd3
    } mode_t;

    typedef struct packed {
        logic [CNT_W-1:0]  period;
        logic [CNT_W-1:0]  duty;
        logic [DATA_W-1:0] amp;
        logic [DATA_W-1:0] step;
        mode_t             mode;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{
        period: CNT_W'(DEFAULT_PERIOD),
        duty:   CNT_W'(DEFAULT_PERIOD / 2),
        amp:    {2'b00, {(DATA_W-2){1'b1}}},
        step:   DATA_W'(1),
        mode:   MODE_SQUARE
    };

    cfg_t             act_r;
    cfg_t             pend_r;
    cfg_t             cap_cfg;
    logic             pend;
    logic [CNT_W-1:0] count_r;

    logic [DATA_W:0]   up_sum;
    logic [DATA_W-1:0] up_sat;
    logic [DATA_W-1:0] dn_sat;
    logic [DATA_W-1:0] next_sample;
    logic              last;

    // Period below 2 is forced to 2 as the settings are captured.
    always_comb begin
        cap_cfg.period = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
        cap_cfg.duty   = cfg_duty;
        cap_cfg.amp    = cfg_amp;
        cap_cfg.step   = cfg_step;
        cap_cfg.mode   = mode_t'(cfg_mode);
    end

    // data doubles as the previous level L; the up-sum carries one extra bit so it saturates.
    always_comb begin
        up_sum      = {1'b0, data} + {1'b0, act_r.step};
        up_sat      = (up_sum > {1'b0, act_r.amp}) ? act_r.amp : up_sum[DATA_W-1:0];
        dn_sat      = (data > act_r.step) ? (data - act_r.step) : '0;
        last        = (count_r == act_r.period - CNT_W'(1));
        next_sample = '0;
        case (act_r.mode)
            MODE_SQUARE: next_sample = (count_r < act_r.duty) ? act_r.amp : '0;
            MODE_SAW:    next_sample = (count_r == '0) ? '0 : up_sat;
            MODE_TRI: begin
                if (count_r == '0)
                    next_sample = '0;
                else if (count_r < (act_r.period >> 1))
                    next_sample = up_sat;
                else
                    next_sample = dn_sat;
            end
            default:     next_sample = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            act_r   <= DEF_CFG;
            pend_r  <= DEF_CFG;
            pend    <= 1'b0;
            count_r <= '0;
            data    <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            valid <= 1'b0;
            wrap  <= 1'b0;
            if (load) begin
                pend_r <= cap_cfg;
                pend   <= 1'b1;
            end
            if (!enable) begin
                count_r <= '0;
                data    <= '0;
                if (pend) begin
                    act_r <= pend_r;
                    pend  <= load;
                end
            end else if (sample_en) begin
                data  <= next_sample;
                valid <= 1'b1;
                if (last) begin
                    count_r <= '0;
                    wrap    <= 1'b1;
                    // A load on the boundary sample bypasses the pending buffer.
                    if (load) begin
                        act_r <= cap_cfg;
                        pend  <= 1'b0;
                    end else if (pend) begin
                        act_r <= pend_r;
                        pend  <= 1'b0;
                    end
                end else begin
                    count_r <= count_r + CNT_W'(1);
                end
            end
        end
    end

endmodule
